// File: rtl/alu_8bit.sv
// 8-bit registered ALU with an internal accumulator.
// Each clock edge, one of 16 opcode-selected results is loaded into acc, and acc drives ALU_Out.
module alu_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] opcode,
    output logic [7:0] ALU_Out
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_ADDA = 4'b0100;
    localparam logic [3:0] OP_MULA = 4'b0101;
    localparam logic [3:0] OP_MAC  = 4'b0110;
    localparam logic [3:0] OP_ROL  = 4'b0111;
    localparam logic [3:0] OP_ROR  = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1001;
    localparam logic [3:0] OP_OR   = 4'b1010;
    localparam logic [3:0] OP_XOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_ETH  = 4'b1101;
    localparam logic [3:0] OP_GTH  = 4'b1110;
    localparam logic [3:0] OP_LTH  = 4'b1111;

    // acc keeps this plain name so that benches can deposit into it hierarchically.
    logic [7:0] acc;
    logic [7:0] acc_d;
    logic [7:0] prod_ab;
    logic [7:0] prod_acc_a;
    logic [7:0] quot_ab;

    always_comb begin
        prod_ab    = A * B;
        prod_acc_a = acc * A;
        quot_ab    = (B == 8'h00) ? 8'hFF : (A / B);
    end

    always_comb begin
        acc_d = acc;
        case (opcode)
            OP_ADD:  acc_d = A + B;
            OP_SUB:  acc_d = A - B;
            OP_MUL:  acc_d = prod_ab;
            OP_DIV:  acc_d = quot_ab;
            OP_ADDA: acc_d = acc + A;
            OP_MULA: acc_d = prod_acc_a;
            OP_MAC:  acc_d = acc + prod_ab;
            OP_ROL:  acc_d = {A[6:0], A[7]};
            OP_ROR:  acc_d = {A[0], A[7:1]};
            OP_AND:  acc_d = A & B;
            OP_OR:   acc_d = A | B;
            OP_XOR:  acc_d = A ^ B;
            OP_NAND: acc_d = ~(A & B);
            OP_ETH:  acc_d = (A == B) ? 8'h01 : 8'h00;
            OP_GTH:  acc_d = (A > B)  ? 8'h01 : 8'h00;
            OP_LTH:  acc_d = (A < B)  ? 8'h01 : 8'h00;
            default: acc_d = acc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 8'h00;
        end else begin
            acc <= acc_d;
        end
    end

    assign ALU_Out = acc;

endmodule

// File: tb/tb_alu_8bit.sv
// Scoreboard bench for alu_8bit: directed ops push hand-computed results,
// and a monitor compares ALU_Out one step after each rising edge.
module tb_alu_8bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] opcode;
    logic [7:0] ALU_Out;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } sb_entry_t;

    sb_entry_t sb[$];
    int checks = 0;
    int fails  = 0;

    alu_8bit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .opcode  (opcode),
        .ALU_Out (ALU_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The result of an edge is checked 1 time unit after that edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            sb_entry_t e;
            e = sb.pop_front();
            checks++;
            if (ALU_Out !== e.exp) begin
                fails++;
                $display("FAIL %s: ALU_Out=%h expected=%h", e.name, ALU_Out, e.exp);
            end else begin
                $display("ok   %s: ALU_Out=%h", e.name, ALU_Out);
            end
        end
    end

    task automatic op(input logic [3:0] opc, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp, input string name);
        sb_entry_t e;
        @(negedge clk);
        opcode = opc;
        A      = a;
        B      = b;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic direct_check(input logic [7:0] exp, input string name);
        checks++;
        if (ALU_Out !== exp) begin
            fails++;
            $display("FAIL %s: ALU_Out=%h expected=%h", name, ALU_Out, exp);
        end else begin
            $display("ok   %s: ALU_Out=%h", name, ALU_Out);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        A      = 8'h5A;
        B      = 8'h3C;
        opcode = 4'b0000;
        #3;
        direct_check(8'h00, "reset_before_edge");
        repeat (2) @(posedge clk);
        #1;
        direct_check(8'h00, "reset_held_over_edges");
        @(negedge clk);
        rst_n = 1'b1;

        op(4'b0000, 8'h0A, 8'h05, 8'h0F, "add_0a_05");
        op(4'b0001, 8'h00, 8'h01, 8'hFF, "sub_wrap_00_01");
        op(4'b0001, 8'hFF, 8'hFF, 8'h00, "sub_ff_ff");
        op(4'b0011, 8'h08, 8'h00, 8'hFF, "div_by_zero");
        op(4'b0011, 8'h08, 8'h08, 8'h01, "div_08_08");
        op(4'b0010, 8'h13, 8'h11, 8'h43, "mul_13_11_low");

        // Seed acc = 0x05 with an ADD, then accumulate 0x0A*0x05 = 0x32 per edge.
        op(4'b0000, 8'h05, 8'h00, 8'h05, "seed_acc_05");
        op(4'b0110, 8'h0A, 8'h05, 8'h37, "mac_1");
        op(4'b0110, 8'h0A, 8'h05, 8'h69, "mac_2");
        op(4'b0110, 8'h0A, 8'h05, 8'h9B, "mac_3");
        op(4'b0110, 8'h0A, 8'h05, 8'hCD, "mac_4");
        op(4'b0110, 8'h0A, 8'h05, 8'hFF, "mac_5");
        op(4'b0110, 8'h0A, 8'h05, 8'h31, "mac_6_wrap");
        op(4'b0000, 8'h00, 8'h00, 8'h00, "seed_acc_00");
        op(4'b0110, 8'h34, 8'h02, 8'h68, "mac_34_02");
        op(4'b0101, 8'h03, 8'hEE, 8'h38, "mula_68x3");

        op(4'b0111, 8'hB1, 8'h00, 8'h63, "rol_b1");
        op(4'b0111, 8'h80, 8'h00, 8'h01, "rol_80");
        op(4'b1000, 8'hB1, 8'h00, 8'hD8, "ror_b1");
        op(4'b1000, 8'h01, 8'h00, 8'h80, "ror_01");

        op(4'b1001, 8'hAA, 8'h55, 8'h00, "and_aa_55");
        op(4'b1010, 8'h08, 8'h02, 8'h0A, "or_08_02");
        op(4'b1011, 8'h08, 8'h0A, 8'h02, "xor_08_0a");
        op(4'b1100, 8'hAA, 8'h55, 8'hFF, "nand_aa_55");
        op(4'b1101, 8'h09, 8'h09, 8'h01, "eth_09_09");
        op(4'b1101, 8'h09, 8'h08, 8'h00, "eth_09_08");
        op(4'b1110, 8'hAA, 8'h55, 8'h01, "gth_aa_55");
        op(4'b1110, 8'h0A, 8'h55, 8'h00, "gth_0a_55");
        op(4'b1111, 8'h0A, 8'h55, 8'h01, "lth_0a_55");
        op(4'b1111, 8'h09, 8'h09, 8'h00, "lth_09_09");

        // Output must hold between edges even if inputs move.
        @(negedge clk);
        A      = 8'hFF;
        B      = 8'h00;
        opcode = 4'b0000;
        #1;
        direct_check(8'h00, "hold_between_edges");

        op(4'b0000, 8'h02, 8'h00, 8'h02, "seed_acc_02");
        op(4'b0100, 8'h10, 8'h77, 8'h12, "adda_1");
        op(4'b0100, 8'h10, 8'h77, 8'h22, "adda_2");
        op(4'b0100, 8'h10, 8'h77, 8'h32, "adda_3");

        // Asynchronous reset pulse between edges, ADDA still selected.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        direct_check(8'h00, "async_reset_mid_seq");
        #1;
        rst_n = 1'b1;
        begin
            sb_entry_t e;
            e.exp  = 8'h10;
            e.name = "adda_after_reset";
            sb.push_back(e);
        end

        begin
            int budget;
            budget = 0;
            while (sb.size() > 0 && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            if (sb.size() > 0) begin
                checks++;
                fails++;
                $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
